logic_func_tester: RTL and testbench

LOGIC_FUNC_TESTER -- requirements
Module: logic_func_tester

---
 rtl/logic_func_pkg.sv | 17 +
 rtl/logic_func_ref.sv | 18 +
 rtl/logic_func_tester.sv | 135 +++++++++++++
 tb/tb_logic_func_tester.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_func_pkg.sv
// Shared types and sizing constants for the logic function tester.
package logic_func_pkg;

    localparam int unsigned VEC_COUNT = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned ERR_W     = 4;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/logic_func_ref.sv
// Golden combinational model of the device under test.
module logic_func_ref (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic X,
    output logic Y,
    output logic Z
);

    logic b_eq_c;

    assign b_eq_c = ~(B ^ C);
    assign X      = ~A | b_eq_c;
    assign Y      = (~B & C) | (A & B);
    assign Z      = A | (b_eq_c & (A | B));

endmodule

// File: rtl/logic_func_tester.sv
// Exhaustive 3-input functional tester: walks all vectors, compares DUT
// responses against the golden model and records per-vector failures.
module logic_func_tester
    import logic_func_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             x_i,
    input  logic             y_i,
    input  logic             z_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_vec
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         abc_d;
    logic               busy_d, done_d, pass_d;
    logic [ERR_W-1:0]   err_d;
    logic [7:0]         fail_d;
    logic               ref_x, ref_y, ref_z;
    logic               vec_fail;

    logic_func_ref u_ref (
        .A (idx_q[2]),
        .B (idx_q[1]),
        .C (idx_q[0]),
        .X (ref_x),
        .Y (ref_y),
        .Z (ref_z)
    );

    assign vec_fail = ({x_i, y_i, z_i} != {ref_x, ref_y, ref_z});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            c_o       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            a_o       <= abc_d[2];
            b_o       <= abc_d[1];
            c_o       <= abc_d[0];
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_vec  <= fail_d;
        end
    end

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = {a_o, b_o, c_o};
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        fail_d  = fail_vec;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            DRIVE: begin
                abc_d   = idx_q;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (vec_fail) begin
                    fail_d[idx_q] = 1'b1;
                    if (err_count != ERR_W'(VEC_COUNT)) begin
                        err_d = err_count + ERR_W'(1);
                    end
                end
                // pass must reflect this final check, so use err_d not err_count
                if (idx_q == IDX_W'(VEC_COUNT - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_logic_func_tester.sv
// Scoreboard bench for logic_func_tester: a behavioural DUT responder with
// selectable faults, expected results queued at start, checked on done.
module tb_logic_func_tester;

    localparam time PERIOD = 10;

    typedef struct {
        logic [7:0] fv;
        logic [3:0] ec;
        logic       ps;
        time        t;
    } exp_t;

    logic       clk, rst_n, start0, start1;
    logic       a0, b0, c0, x0, y0, z0, busy0, done0, pass0;
    logic       a1, b1, c1, x1, y1, z1, busy1, done1, pass1;
    logic [3:0] err0, err1;
    logic [7:0] fv0, fv1;

    int         mode;
    logic [2:0] fault_mask [8];
    exp_t       q0 [$];
    exp_t       q1 [$];
    int         n_chk = 0;
    int         n_fail = 0;

    logic_func_tester #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a_o(a0), .b_o(b0), .c_o(c0), .x_i(x0), .y_i(y0), .z_i(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
    );

    logic_func_tester #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_o(a1), .b_o(b1), .c_o(c1), .x_i(x1), .y_i(y1), .z_i(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    // Golden responses straight from the boolean rules, on integer operands.
    function automatic logic [2:0] gold(input logic [2:0] i);
        int a, b, c;
        logic x, y, z;
        a = int'(i[2]);
        b = int'(i[1]);
        c = int'(i[0]);
        x = (a == 0) || (b == c);
        y = (b == 0 && c == 1) || (a == 1 && b == 1);
        z = (a == 1) || ((b == c) && (a + b > 0));
        return {x, y, z};
    endfunction

    // Mode 0: correct, 1: y stuck 0, 2: x stuck 1, 3: random per-vector bit flips.
    function automatic logic [2:0] resp(input int m, input logic [2:0] i, input logic [2:0] f);
        logic [2:0] r;
        r = gold(i);
        if (m == 3) r = r ^ f;
        if (m == 1) r[1] = 1'b0;
        if (m == 2) r[2] = 1'b1;
        return r;
    endfunction

    assign {x0, y0, z0} = resp(mode, {a0, b0, c0}, fault_mask[{a0, b0, c0}]);
    assign {x1, y1, z1} = gold({a1, b1, c1});

    function automatic exp_t expect_run(input int m, input time t);
        exp_t e;
        e.fv = '0;
        for (int i = 0; i < 8; i++) begin
            if (resp(m, 3'(i), fault_mask[i]) != gold(3'(i))) e.fv[i] = 1'b1;
        end
        e.ec = 4'($countones(e.fv));
        e.ps = (e.ec == 4'd0);
        e.t  = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the SETTLE_CYCLES=2 instance.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done0 && !prev) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut0_unexpected_done: got done=1 expected no run at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_fail_vec", 64'(fv0), 64'(e.fv));
                    chk("dut0_err_count", 64'(err0), 64'(e.ec));
                    chk("dut0_pass", 64'(pass0), 64'(e.ps));
                    chk("dut0_busy_at_done", 64'(busy0), 64'd0);
                    chk("dut0_done_time", 64'($time - 1), 64'(e.t));
                end
            end
            prev = done0;
        end
    end

    // Monitor for the SETTLE_CYCLES=1 instance.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done1 && !prev) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut1_unexpected_done: got done=1 expected no run at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_fail_vec", 64'(fv1), 64'(e.fv));
                    chk("dut1_err_count", 64'(err1), 64'(e.ec));
                    chk("dut1_pass", 64'(pass1), 64'(e.ps));
                    chk("dut1_done_time", 64'($time - 1), 64'(e.t));
                end
            end
            prev = done1;
        end
    end

    task automatic run_start0(input bit push);
        time t0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        t0 = $time;
        if (push) q0.push_back(expect_run(mode, t0 + 32 * PERIOD));
        #1;
        chk("start_busy", 64'(busy0), 64'd1);
        chk("start_clears_done", 64'(done0), 64'd0);
        chk("start_clears_err", 64'(err0), 64'd0);
        chk("start_clears_fail_vec", 64'(fv0), 64'd0);
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic wait_drain(input int which, input int maxc);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (((which == 0) ? q0.size() : q1.size()) != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: dut%0d still waiting for done after %0d cycles", which, maxc);
            if (which == 0) q0.delete(); else q1.delete();
        end
    endtask

    task automatic check_idle0(input string name);
        chk(name, 64'({busy0, done0, pass0, a0, b0, c0, err0, fv0}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        for (int i = 0; i < 8; i++) fault_mask[i] = 3'd0;

        #22;
        check_idle0("reset_outputs");
        chk("reset_outputs_dut1", 64'({busy1, done1, pass1, a1, b1, c1, err1, fv1}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle0("no_run_without_start");

        // SETTLE_CYCLES=1 instance: 24-cycle run
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        q1.push_back(expect_run(0, $time + 24 * PERIOD));
        @(negedge clk) start1 = 1'b0;
        wait_drain(1, 60);

        // Correct DUT, y stuck 0, x stuck 1
        for (int m = 0; m < 3; m++) begin
            mode = m;
            run_start0(1'b1);
            wait_drain(0, 60);
        end

        // Extra starts while busy are ignored; then restart from DONE
        mode = 1;
        run_start0(1'b1);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            start0 = 1'b1;
            @(negedge clk) start0 = 1'b0;
        end
        wait_drain(0, 60);
        run_start0(1'b1);
        wait_drain(0, 60);

        // start held high through DONE begins a second run immediately
        mode = 0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        t0 = $time;
        q0.push_back(expect_run(0, t0 + 32 * PERIOD));
        q0.push_back(expect_run(0, t0 + 33 * PERIOD + 32 * PERIOD));
        repeat (34) @(negedge clk);
        start0 = 1'b0;
        wait_drain(0, 80);

        // Randomised fault patterns
        mode = 3;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++)
                fault_mask[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            run_start0(1'b1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 20)) @(negedge clk);
                start0 = 1'b1;
                @(negedge clk) start0 = 1'b0;
            end
            wait_drain(0, 60);
        end
        for (int i = 0; i < 8; i++) fault_mask[i] = 3'd0;

        // Reset during SETTLE of vector 4
        mode = 1;
        run_start0(1'b0);
        #(17 * PERIOD - 1);
        chk("pre_reset_busy", 64'(busy0), 64'd1);
        chk("pre_reset_vector", 64'({a0, b0, c0}), 64'd4);
        chk("pre_reset_err", 64'(err0), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_idle0("async_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle0("idle_after_reset");
        end

        mode = 0;
        run_start0(1'b1);
        wait_drain(0, 60);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
